// File: rtl/pipe_line_rx.sv
// Receive stage of the temperature-telemetry serial link: UART-style deserialiser with
// parity/framing checks and alarm/shutdown flags. Optional RX_INPUT_SYNC_EN adds a 2-flop din synchroniser.
module pipe_line_rx #(
  parameter int DIV0        = 16,
  parameter int DIV1        = 32,
  parameter int DIV2        = 64,
  parameter int DIV3        = 128,
  parameter int ALARM_TH    = 120,
  parameter int SHUTDOWN_TH = 200
) (
  output logic [7:0] temp_out,
  output logic       parity_warning,
  output logic       frame_warning,
  output logic       shutdown,
  output logic       alarm,
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] bd_rate,
  input  logic       dnum,
  input  logic       snum,
  input  logic [1:0] par,
  input  logic       din,
  output logic [7:0] data
);

  localparam logic [7:0] D0        = 8'(DIV0);
  localparam logic [7:0] D1        = 8'(DIV1);
  localparam logic [7:0] D2        = 8'(DIV2);
  localparam logic [7:0] D3        = 8'(DIV3);
  localparam logic [7:0] ALARM_LVL = 8'(ALARM_TH);
  localparam logic [7:0] SHUT_LVL  = 8'(SHUTDOWN_TH);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t state, state_nxt;

  logic       rx;
  logic       rx_q;
  logic [1:0] cfg_bd;
  logic       cfg_dnum;
  logic       cfg_snum;
  logic [1:0] cfg_par;
  logic [7:0] baud_cnt;
  logic [2:0] bit_cnt;
  logic [7:0] shreg;
  logic       par_err;
  logic       stop_err;

  logic [7:0] div_sel;
  logic [7:0] half_m1;
  logic       tick_half;
  logic       tick_full;
  logic       fall;
  logic       last_data;
  logic       last_stop;
  logic       par_en;
  logic [7:0] data_byte;
  logic       frame_err;

`ifdef RX_INPUT_SYNC_EN
  logic [1:0] sync_q;

  always_ff @(posedge clk) begin
    if (rst) sync_q <= 2'b11;
    else     sync_q <= {sync_q[0], din};
  end

  assign rx = sync_q[1];
`else
  assign rx = din;
`endif

  always_comb begin
    div_sel = D0;
    case (cfg_bd)
      2'b00:   div_sel = D0;
      2'b01:   div_sel = D1;
      2'b10:   div_sel = D2;
      default: div_sel = D3;
    endcase
  end

  assign half_m1   = (div_sel >> 1) - 8'd1;
  assign tick_half = (baud_cnt == half_m1);
  assign tick_full = (baud_cnt == div_sel - 8'd1);
  assign fall      = rx_q & ~rx;
  assign last_data = (bit_cnt == (cfg_dnum ? 3'd6 : 3'd7));
  assign last_stop = cfg_snum ? (bit_cnt == 3'd1) : 1'b1;
  assign par_en    = (cfg_par == 2'b01) || (cfg_par == 2'b10);
  // 7-bit frames finish with their LSB one position higher in the shifter
  assign data_byte = cfg_dnum ? {1'b0, shreg[7:1]} : shreg;
  assign frame_err = stop_err | ~rx;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (fall) state_nxt = S_START;
      S_START:  if (tick_half) state_nxt = rx ? S_IDLE : S_DATA;
      S_DATA:   if (tick_full && last_data) state_nxt = par_en ? S_PARITY : S_STOP;
      S_PARITY: if (tick_full) state_nxt = S_STOP;
      S_STOP:   if (tick_full && last_stop) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_q           <= 1'b1;
      cfg_bd         <= 2'b00;
      cfg_dnum       <= 1'b0;
      cfg_snum       <= 1'b0;
      cfg_par        <= 2'b00;
      baud_cnt       <= 8'd0;
      bit_cnt        <= 3'd0;
      shreg          <= 8'd0;
      par_err        <= 1'b0;
      stop_err       <= 1'b0;
      temp_out       <= 8'd0;
      data           <= 8'd0;
      parity_warning <= 1'b0;
      frame_warning  <= 1'b0;
      alarm          <= 1'b0;
      shutdown       <= 1'b0;
    end else begin
      rx_q     <= rx;
      alarm    <= (temp_out >= ALARM_LVL);
      shutdown <= (temp_out >= SHUT_LVL);
      case (state)
        S_IDLE: begin
          baud_cnt <= 8'd0;
          bit_cnt  <= 3'd0;
          if (fall) begin
            cfg_bd   <= bd_rate;
            cfg_dnum <= dnum;
            cfg_snum <= snum;
            cfg_par  <= par;
            par_err  <= 1'b0;
            stop_err <= 1'b0;
          end
        end
        S_START: begin
          bit_cnt  <= 3'd0;
          baud_cnt <= tick_half ? 8'd0 : baud_cnt + 8'd1;
        end
        S_DATA: begin
          if (tick_full) begin
            baud_cnt <= 8'd0;
            shreg    <= {rx, shreg[7:1]};
            bit_cnt  <= last_data ? 3'd0 : bit_cnt + 3'd1;
          end else begin
            baud_cnt <= baud_cnt + 8'd1;
          end
        end
        S_PARITY: begin
          if (tick_full) begin
            baud_cnt <= 8'd0;
            // odd mode expects an odd total of ones, even mode an even total
            par_err  <= (^data_byte) ^ rx ^ (cfg_par == 2'b01);
          end else begin
            baud_cnt <= baud_cnt + 8'd1;
          end
        end
        S_STOP: begin
          if (tick_full) begin
            baud_cnt <= 8'd0;
            bit_cnt  <= bit_cnt + 3'd1;
            stop_err <= frame_err;
            if (last_stop) begin
              data           <= data_byte;
              parity_warning <= par_err;
              frame_warning  <= frame_err;
              if (!par_err && !frame_err) temp_out <= data_byte;
            end
          end else begin
            baud_cnt <= baud_cnt + 8'd1;
          end
        end
        default: begin
          baud_cnt <= 8'd0;
          bit_cnt  <= 3'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_line_rx.sv
// Bench for pipe_line_rx: frame-level reference model checked every idle cycle,
// directed frames pinned with literal values, then randomized frames.
module tb_pipe_line_rx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] bd_rate = 2'b00;
  logic       dnum = 1'b0;
  logic       snum = 1'b0;
  logic [1:0] par = 2'b00;
  logic       din = 1'b1;
  logic [7:0] temp_out;
  logic       parity_warning;
  logic       frame_warning;
  logic       shutdown;
  logic       alarm;
  logic [7:0] data;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  // Reference model: output values expected once a frame has been fully delivered.
  logic [7:0] m_temp, m_data;
  logic       m_pw, m_fw, m_alarm, m_shut;

  pipe_line_rx dut (
    .temp_out       (temp_out),
    .parity_warning (parity_warning),
    .frame_warning  (frame_warning),
    .shutdown       (shutdown),
    .alarm          (alarm),
    .clk            (clk),
    .rst            (rst),
    .bd_rate        (bd_rate),
    .dnum           (dnum),
    .snum           (snum),
    .par            (par),
    .din            (din),
    .data           (data)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_temp_out", 32'(temp_out), 32'(m_temp));
      check("cyc_data", 32'(data), 32'(m_data));
      check("cyc_parity_warning", 32'(parity_warning), 32'(m_pw));
      check("cyc_frame_warning", 32'(frame_warning), 32'(m_fw));
      check("cyc_alarm", 32'(alarm), 32'(m_alarm));
      check("cyc_shutdown", 32'(shutdown), 32'(m_shut));
    end
  end

  task automatic model_reset();
    m_temp = 8'd0; m_data = 8'd0; m_pw = 1'b0; m_fw = 1'b0; m_alarm = 1'b0; m_shut = 1'b0;
  endtask

  task automatic hold_bit(input logic v, input int div);
    din = v;
    repeat (div) @(negedge clk);
  endtask

  // Sends one frame; bad_stop[i] drives stop bit i low, bad_par inverts the parity bit.
  task automatic send_frame(input logic [7:0] b, input logic [1:0] bd, input logic dn,
                            input logic sn, input logic [1:0] pr, input logic bad_par,
                            input logic [1:0] bad_stop);
    int div;
    int nbits;
    int nstop;
    logic [7:0] val;
    logic pbit;
    logic p_en;
    logic pw, fw;
    div   = 16 << bd;
    nbits = dn ? 7 : 8;
    nstop = sn ? 2 : 1;
    val   = dn ? {1'b0, b[6:0]} : b;
    p_en  = (pr == 2'b01) || (pr == 2'b10);
    pbit  = ($countones(val) % 2 == 1) ? (pr == 2'b10) : (pr == 2'b01);
    if (bad_par) pbit = ~pbit;
    bd_rate = bd; dnum = dn; snum = sn; par = pr;
    hold_bit(1'b0, div);
    for (int i = 0; i < nbits; i++) hold_bit(val[i], div);
    if (p_en) hold_bit(pbit, div);
    for (int s = 0; s < nstop; s++) begin
      if (s == nstop - 1) chk_en = 1'b0;
      hold_bit(~bad_stop[s], div);
    end
    din = 1'b1;
    pw = p_en && bad_par;
    fw = sn ? (bad_stop != 2'b00) : bad_stop[0];
    m_data = val;
    m_pw   = pw;
    m_fw   = fw;
    if (!pw && !fw) m_temp = val;
    m_alarm = (m_temp >= 8'd120);
    m_shut  = (m_temp >= 8'd200);
    chk_en = 1'b1;
  endtask

  task automatic idle(input int n);
    din = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    logic [7:0] b;
    logic [1:0] bd, pr, bs;
    logic dn, sn, bp;
    int gap;

    model_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_temp_out", 32'(temp_out), 32'h0);
    check("rst_data", 32'(data), 32'h0);
    check("rst_warnings", 32'({parity_warning, frame_warning}), 32'h0);
    check("rst_alarm_shutdown", 32'({alarm, shutdown}), 32'h0);
    chk_en = 1'b1;
    idle(20);

    send_frame(8'h8F, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00);
    idle(3);
    check("f8f_data", 32'(data), 32'h8F);
    check("f8f_temp_out", 32'(temp_out), 32'h8F);
    check("f8f_alarm", 32'(alarm), 32'h1);
    check("f8f_shutdown", 32'(shutdown), 32'h0);
    check("f8f_warnings", 32'({parity_warning, frame_warning}), 32'h0);

    send_frame(8'hD2, 2'b00, 1'b0, 1'b0, 2'b10, 1'b1, 2'b00);
    idle(3);
    check("fd2_data", 32'(data), 32'hD2);
    check("fd2_parity_warning", 32'(parity_warning), 32'h1);
    check("fd2_temp_out", 32'(temp_out), 32'h8F);

    send_frame(8'h55, 2'b00, 1'b0, 1'b1, 2'b00, 1'b0, 2'b10);
    idle(3);
    check("stop2_frame_warning", 32'(frame_warning), 32'h1);
    check("stop2_temp_out", 32'(temp_out), 32'h8F);

    send_frame(8'h10, 2'b01, 1'b0, 1'b1, 2'b00, 1'b0, 2'b00);
    idle(3);
    check("f10_warnings", 32'({parity_warning, frame_warning}), 32'h0);
    check("f10_temp_out", 32'(temp_out), 32'h10);
    check("f10_alarm", 32'(alarm), 32'h0);

    send_frame(8'h7F, 2'b00, 1'b1, 1'b0, 2'b01, 1'b0, 2'b00);
    idle(3);
    check("f7f_data", 32'(data), 32'h7F);
    check("f7f_warnings", 32'({parity_warning, frame_warning}), 32'h0);

    send_frame(8'hC8, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00);
    idle(3);
    check("fc8_shutdown", 32'(shutdown), 32'h1);
    check("fc8_alarm", 32'(alarm), 32'h1);

    // Short low pulse at the slowest rate must be rejected as a false start.
    bd_rate = 2'b11; dnum = 1'b0; snum = 1'b0; par = 2'b00;
    din = 1'b0;
    repeat (3) @(negedge clk);
    idle(200);
    check("glitch_temp_out", 32'(temp_out), 32'hC8);
    check("glitch_data", 32'(data), 32'hC8);

    for (int k = 0; k < 30; k++) begin
      b   = 8'($urandom_range(0, 255));
      bd  = ($urandom_range(0, 3) == 3) ? 2'b11 : 2'($urandom_range(0, 2));
      dn  = 1'($urandom_range(0, 1));
      sn  = 1'($urandom_range(0, 1));
      pr  = 2'($urandom_range(0, 3));
      bp  = ($urandom_range(0, 3) == 0);
      bs  = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      gap = $urandom_range(0, 5);
      if (bs != 2'b00 && gap < 2) gap = 2;
      send_frame(b, bd, dn, sn, pr, bp, bs);
      idle(gap);
    end
    idle(5);

    // Reset in the middle of a frame discards it and clears every output.
    bd_rate = 2'b00; dnum = 1'b0; snum = 1'b0; par = 2'b00;
    hold_bit(1'b0, 16);
    hold_bit(1'b1, 16);
    hold_bit(1'b0, 8);
    chk_en = 1'b0;
    rst = 1'b1;
    din = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
    check("midrst_temp_out", 32'(temp_out), 32'h0);
    check("midrst_data", 32'(data), 32'h0);
    check("midrst_flags", 32'({parity_warning, frame_warning, alarm, shutdown}), 32'h0);
    chk_en = 1'b1;
    idle(300);

    send_frame(8'hA5, 2'b01, 1'b0, 1'b0, 2'b10, 1'b0, 2'b00);
    idle(3);
    check("after_rst_temp_out", 32'(temp_out), 32'hA5);
    chk_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
